// File: rtl/dbus_sram_responder.sv
// Data-bus responder: word-organised SRAM behind the dbus request/response
// handshake, with a programmable response latency.
module dbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        dresp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] OOR_DATA   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_data;
  logic [3:0]         lat_strobe;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  // Word index of the latched request; range check uses the full byte offset
  assign offset   = lat_addr - BASE_ADDR;
  assign in_range = (offset < SPAN_BYTES);
  assign idx      = offset[IDX_W+1:2];

  // Handshake FSM; responses are registered at the edge ending RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 32'h0;
      dresp_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 32'h0;
      dresp_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq_valid) begin
            lat_addr   <= dreq_addr;
            lat_data   <= dreq_data;
            lat_strobe <= dreq_strobe;
            busy       <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state         <= IDLE;
          busy          <= 1'b0;
          dresp_addr_ok <= 1'b1;
          dresp_data_ok <= 1'b1;
          dresp_err     <= ~in_range;
          if (!in_range) begin
            dresp_data <= OOR_DATA;
          end else if (lat_strobe == 4'b0000) begin
            dresp_data <= mem[idx];
          end else begin
            dresp_data <= 32'h0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-masked array write at the edge ending RESP; reset cancels it
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_strobe[i]) begin
          mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: four instances at latencies 2, 1, 7 and 4,
// a per-cycle transaction model, and directed vectors with literal results.
module tb_dbus_sram_responder;

  localparam int unsigned N = 4;

  logic        clk;
  logic        rst    [N];
  logic        dv     [N];
  logic [31:0] da     [N];
  logic [3:0]  ds     [N];
  logic [31:0] dd     [N];
  logic        aok    [N];
  logic        ok     [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic        bsy    [N];

  int checks   = 0;
  int failures = 0;

  function automatic int unsigned lat_of(input int g);
    case (g)
      0: return 2;
      1: return 1;
      2: return 7;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    dbus_sram_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 7 : 4),
      .BASE_ADDR(32'h0000_0000)
    ) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .dreq_valid   (dv[g]),
      .dreq_addr    (da[g]),
      .dreq_strobe  (ds[g]),
      .dreq_data    (dd[g]),
      .dresp_addr_ok(aok[g]),
      .dresp_data_ok(ok[g]),
      .dresp_data   (rdata[g]),
      .dresp_err    (err[g]),
      .busy         (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: accept when idle and free, respond LATENCY edges later
  int unsigned cyc = 0;
  bit          pend   [N];
  int unsigned acc_e  [N];
  int unsigned free_e [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  logic [3:0]  m_strb [N];
  bit          e_ok   [N];
  bit          e_err  [N];
  bit          e_busy [N];
  logic [31:0] e_data [N];
  int unsigned ok_cnt [N];
  logic [31:0] mmem   [N][1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < N; g++) begin
      e_ok[g]   = 1'b0;
      e_err[g]  = 1'b0;
      e_data[g] = 32'h0;
      if (rst[g]) begin
        pend[g]   = 1'b0;
        free_e[g] = cyc + 1;
      end else begin
        if (pend[g] && cyc == acc_e[g] + lat_of(g)) begin
          int unsigned w;
          pend[g]   = 1'b0;
          free_e[g] = cyc + 1;
          e_ok[g]   = 1'b1;
          w         = m_addr[g] >> 2;
          if (m_addr[g] >= 32'd4096) begin
            e_err[g]  = 1'b1;
            e_data[g] = 32'hDEAD_BEEF;
          end else if (m_strb[g] == 4'b0000) begin
            e_data[g] = mmem[g][w];
          end else begin
            for (int b = 0; b < 4; b++)
              if (m_strb[g][b]) mmem[g][w][8*b +: 8] = m_data[g][8*b +: 8];
          end
        end
        if (!pend[g] && dv[g] && cyc >= free_e[g]) begin
          pend[g]   = 1'b1;
          acc_e[g]  = cyc;
          m_addr[g] = da[g];
          m_data[g] = dd[g];
          m_strb[g] = ds[g];
        end
      end
      e_busy[g] = pend[g];
    end
    #2;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("data_ok[%0d]", g), 32'(ok[g]), 32'(e_ok[g]));
      chk($sformatf("addr_ok[%0d]", g), 32'(aok[g]), 32'(e_ok[g]));
      chk($sformatf("busy[%0d]", g), 32'(bsy[g]), 32'(e_busy[g]));
      chk($sformatf("err[%0d]", g), 32'(err[g]), 32'(e_err[g]));
      chk($sformatf("data[%0d]", g), rdata[g], e_data[g]);
      if (ok[g] === 1'b1) ok_cnt[g]++;
    end
  end

  // Present a request (from the +1 point after an edge) and wait for its response
  task automatic issue(input int g, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic re, output int lat_seen);
    dv[g] = 1'b1;
    da[g] = a;
    ds[g] = s;
    dd[g] = d;
    lat_seen = 0;
    rd = 32'h0;
    re = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ok[g] === 1'b1) begin
        lat_seen = i;
        rd = rdata[g];
        re = err[g];
        break;
      end
    end
    if (lat_seen == 0) begin
      failures++;
      $display("FAIL timeout inst=%0d addr=%h actual=no data_ok expected=data_ok", g, a);
    end
  endtask

  task automatic release_req(input int g);
    dv[g] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        re;
  int          lt;
  int unsigned ok_base;
  int          seen;

  initial begin
    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1; dv[g] = 1'b0; da[g] = 32'h0; ds[g] = 4'h0; dd[g] = 32'h0;
      pend[g] = 1'b0; acc_e[g] = 0; free_e[g] = 0; ok_cnt[g] = 0;
      m_addr[g] = 32'h0; m_data[g] = 32'h0; m_strb[g] = 4'h0;
      for (int w = 0; w < 1024; w++) mmem[g][w] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      chk("reset_busy", 32'(bsy[g]), 32'h0);
      chk("reset_data_ok", 32'(ok[g]), 32'h0);
      chk("reset_data", rdata[g], 32'h0);
      rst[g] = 1'b0;
    end
    @(posedge clk); #1;

    // Write then read at latency 2
    issue(0, 32'h40, 4'hF, 32'h1234_5678, rd, re, lt); release_req(0);
    chk("sw_lat", 32'(lt), 32'd3);
    chk("sw_data", rd, 32'h0);
    @(posedge clk); #1;
    issue(0, 32'h40, 4'h0, 32'h0, rd, re, lt); release_req(0);
    chk("lw_data", rd, 32'h1234_5678);
    chk("lw_err", 32'(re), 32'h0);

    // Byte strobes (address bits [1:0] ignored)
    issue(0, 32'h43, 4'b0101, 32'hAABB_CCDD, rd, re, lt); release_req(0);
    issue(0, 32'h40, 4'h0, 32'h0, rd, re, lt); release_req(0);
    chk("strobe_data", rd, 32'h12BB_56DD);

    // Out of range write and read; word 0 must survive
    issue(0, 32'h0, 4'hF, 32'hCAFE_F00D, rd, re, lt); release_req(0);
    issue(0, 32'h1000, 4'hF, 32'h5555_5555, rd, re, lt); release_req(0);
    chk("oor_wr_err", 32'(re), 32'h1);
    chk("oor_wr_data", rd, 32'hDEAD_BEEF);
    issue(0, 32'h1000, 4'h0, 32'h0, rd, re, lt); release_req(0);
    chk("oor_rd_err", 32'(re), 32'h1);
    chk("oor_rd_data", rd, 32'hDEAD_BEEF);
    issue(0, 32'h0, 4'h0, 32'h0, rd, re, lt); release_req(0);
    chk("mem0_kept", rd, 32'hCAFE_F00D);

    // Latency sweep with held valid: two requests back-to-back per instance
    for (int g = 1; g < N; g++) begin
      issue(g, 32'h80, 4'hF, 32'h0BAD_0000 + 32'(g), rd, re, lt);
      chk($sformatf("lat_first[%0d]", g), 32'(lt), 32'(lat_of(g) + 1));
      issue(g, 32'h80, 4'h0, 32'h0, rd, re, lt); release_req(g);
      chk($sformatf("lat_second[%0d]", g), 32'(lt), 32'(lat_of(g) + 1));
      chk($sformatf("lat_rd[%0d]", g), rd, 32'h0BAD_0000 + 32'(g));
    end

    // Reset two cycles after acceptance at latency 4
    issue(3, 32'h8, 4'hF, 32'h1111_2222, rd, re, lt); release_req(3);
    dv[3] = 1'b1; da[3] = 32'h8; ds[3] = 4'hF; dd[3] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("rst_busy_before", 32'(bsy[3]), 32'h1);
    @(posedge clk); #1;
    rst[3] = 1'b1; dv[3] = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_after", 32'(bsy[3]), 32'h0);
    chk("rst_no_ok", 32'(ok[3]), 32'h0);
    rst[3] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ok[3] === 1'b1) seen++;
    end
    chk("rst_no_pulse", 32'(seen), 32'h0);
    issue(3, 32'h8, 4'h0, 32'h0, rd, re, lt); release_req(3);
    chk("rst_prior_val", rd, 32'h1111_2222);

    // Back-to-back alternating sw/lw stream with valid held throughout
    ok_base = ok_cnt[0];
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(i / 2) * 32'd8;
      if (i % 2 == 0) begin
        issue(0, a, 4'hF, 32'hA500_0000 + 32'(i), rd, re, lt);
      end else begin
        issue(0, a, 4'h0, 32'h0, rd, re, lt);
        chk("stream_rd", rd, 32'hA500_0000 + 32'(i - 1));
      end
      chk("stream_lat", 32'(lt), 32'd3);
    end
    release_req(0);
    repeat (3) @(posedge clk);
    #3;
    chk("stream_pulses", ok_cnt[0] - ok_base, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
